tpfu_core: RTL
==============

Name: tpfu_core

Overview:
Parameterised temporally programmed functional unit, the next generation of the single-FU design.
- Accepts a burst of operand words into a register file, then runs a loadable program of up to 2**PM_AW instructions against it, one per cycle, through a pipelined ALU.
- Streams every result out and writes it back to the register file.
- Sits between the host stream interface and downstream result collection.

Parameters:
DW, 16, data/register width in bits (8..32)
RF_DEPTH, 64, register-file entries (2..64; address fields stay 6 bits)
PM_AW, 4, program-memory address bits (depth 2**PM_AW)
ALU_LAT, 4, issue-to-result latency in cycles (>=1)

Ports:
clk  in  1  clock, all logic rising-edge
rst  in  1  synchronous, active-high reset
prog_we  in  1  program-memory write strobe
prog_addr  in  PM_AW  program-memory write address
prog_data  in  24  instruction word
prog_len  in  PM_AW+1  number of instructions to run, sampled on entry to EXEC
din  in  DW  operand word
din_valid  in  1  operand word valid
din_ready  out  1  core accepts operand words
dout  out  DW  result
dout_valid  out  1  result valid (one-cycle pulse per instruction)
busy  out  1  high in EXEC or DRAIN
done  out  1  one-cycle pulse at end of program

Behaviour:
- Clock and reset: reset rst, synchronous, active-high; clock clk.
- Reset values: din_ready=1, dout=0, dout_valid=0, busy=0, done=0.
  - FSM goes to IDLE; pc and load count are cleared.
  - The ALU pipeline valid bits are flushed.
  - Program memory and register-file contents are preserved.
- Reset mid-operation: in-flight results are discarded; no dout_valid and no done are produced.
- Instruction format: [23:18] opcode, [17:12] dst, [11:6] src1, [5:0] src2 or imm.
  - Opcode[2:0] selects the operation; opcode[5:3] is ignored.
  - 000 NOP, 001 ADD, 010 SUB, 011 MUL, 101 ADDI, 110 SUBI, 111 MULI, 100 NOP.
  - Register operand: src2 register value. Immediate operand: imm zero-extended to DW.
  - SUB computes src1 - operand.
  - MUL keeps the low DW bits of the product.
  - All arithmetic is modulo 2**DW.
  - Register addresses >= RF_DEPTH read 0, and writes to them are dropped.
- Program load: prog_we writes prog_data to pmem[prog_addr] in IDLE or LOAD only. Writes in EXEC or DRAIN are ignored.
- FSM states: IDLE, LOAD, EXEC, DRAIN.
  - IDLE: on din_valid, write din to reg[0], set count=1, go to LOAD.
  - LOAD: each din_valid cycle writes reg[count] and increments count.
    - When din_valid is low and count >= 1, go to EXEC.
    - When count reaches RF_DEPTH, go to EXEC; din_ready drops the same cycle the last word is written.
  - EXEC: din_ready=0, busy=1, pc starts at 0.
    - One instruction is issued per cycle; operands are read from the register file in the issue cycle.
    - After instruction prog_len-1 is issued, go to DRAIN.
    - prog_len=0: go directly to DRAIN with nothing issued.
  - DRAIN: wait until the pipeline is empty, then pulse done for one cycle and go to IDLE. din_ready is reasserted in the IDLE cycle.
- Latency: an instruction issued in cycle t produces dout/dout_valid in cycle t+ALU_LAT.
  - NOPs occupy a slot but produce no dout_valid.
  - The result is written to reg[dst] in the same cycle dout_valid is high.
- Hazards: there is no forwarding. An instruction issued fewer than ALU_LAT cycles after a producer of its source register reads the old value.
- Simultaneous events: if a writeback and a load write target the same register, the writeback wins. This case cannot occur in normal flow and is kept for robustness.
- dout holds its last value when dout_valid is low.

Optional Feature:
TPFU_SAT_EN
- Defined: ADD/ADDI clamp to 2**DW-1 on unsigned overflow; SUB/SUBI clamp to 0 on underflow; MUL/MULI clamp to 2**DW-1 when any product bit above DW-1 is set.
- Undefined: wrap-around arithmetic as specified under Behaviour.
- Latency is identical in both builds.

Test Plan:
- Load din=3,7,10,2; pmem[0]=ADDI dst4 src0 imm5, pmem[1]=MUL dst5 src1 src2, prog_len=2 -> dout_valid at issue+4 with 8, then next cycle 70; reg4=8, reg5=70; done pulses 1 cycle after the last result.
- Load 64 words back to back with din_valid held high -> din_ready low after word 64, EXEC entered automatically, word 65 not accepted.
- prog_len=0 after load -> no dout_valid; done within ALU_LAT+2 cycles of EXEC entry; busy high only in between.
- DW=16, SUBI src=3 imm=5 -> dout=0xFFFE without TPFU_SAT_EN, 0x0000 with it; ADD 0xFFF0+0x0020 -> 0x0010 vs 0xFFFF.
- Assert rst two cycles into EXEC with 4 instructions queued -> dout_valid, busy and done stay 0; din_ready=1 the next cycle; a rerun reproduces correct results from the retained pmem.
- Issue ADDI dst1 src0 imm1 followed immediately by ADDI dst2 src1 imm0 -> second result uses the pre-writeback reg1 value (no forwarding); prog_we during EXEC leaves pmem unchanged.

Source files
------------

// File: rtl/tpfu_core.sv
// Temporally programmed functional unit: burst-loads operands into a register file,
// then runs a stored program through a pipelined ALU. `define TPFU_SAT_EN for saturating arithmetic.
module tpfu_core #(
   parameter int unsigned DW       = 16,
   parameter int unsigned RF_DEPTH = 64,
   parameter int unsigned PM_AW    = 4,
   parameter int unsigned ALU_LAT  = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             prog_we,
   input  logic [PM_AW-1:0] prog_addr,
   input  logic [23:0]      prog_data,
   input  logic [PM_AW:0]   prog_len,
   input  logic [DW-1:0]    din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic [DW-1:0]    dout,
   output logic             dout_valid,
   output logic             busy,
   output logic             done
);

   localparam int unsigned RF_AW    = (RF_DEPTH > 1) ? $clog2(RF_DEPTH) : 1;
   localparam int unsigned PM_DEPTH = 1 << PM_AW;
   localparam int unsigned CW       = 7;
   localparam logic [ALU_LAT-1:0] LAST_MASK = (ALU_LAT)'(1) << (ALU_LAT - 1);

   typedef enum logic [1:0] {IDLE, LOAD, EXEC, DRAIN} state_t;

   state_t         state;
   logic [CW-1:0]  count;
   logic [PM_AW:0] pc;
   logic [PM_AW:0] len_q;

   logic [23:0]    pmem [PM_DEPTH];
   logic [DW-1:0]  rf   [RF_DEPTH];

   logic [ALU_LAT-1:0] p_vld;
   logic [DW-1:0]      p_data [ALU_LAT];
   logic [5:0]         p_dst  [ALU_LAT];

   logic          wb_en;
   logic [5:0]    wb_dst;
   logic [DW-1:0] wb_data;
   logic          ld_en;
   logic [CW-1:0] ld_addr;

   logic [23:0]   instr;
   logic [2:0]    op;
   logic [5:0]    dst, src1, src2;
   logic          issue_c;
   logic          iss_vld;
   logic [DW-1:0] opa, opb;
   logic [DW:0]   sum, diff;
   logic [2*DW-1:0] prod;
   logic [DW-1:0] add_r, sub_r, mul_r, alu_r;

   function automatic logic in_rf(input logic [5:0] a);
      return {1'b0, a} < 7'(RF_DEPTH);
   endfunction

   // Register read with write-through so an issue in the writeback cycle sees the new value
   function automatic logic [DW-1:0] rf_rd(input logic [5:0] a);
      if (!in_rf(a))
         return '0;
      else if (wb_en && (wb_dst == a))
         return wb_data;
      else
         return rf[a[RF_AW-1:0]];
   endfunction

   assign wb_dst  = p_dst[ALU_LAT-1];
   assign wb_data = p_data[ALU_LAT-1];
   assign wb_en   = !rst && p_vld[ALU_LAT-1] && in_rf(wb_dst);
   assign ld_en   = !rst && din_valid && din_ready && ((state == IDLE) || (state == LOAD));
   assign ld_addr = (state == IDLE) ? '0 : count;

   assign instr   = pmem[pc[PM_AW-1:0]];
   assign op      = instr[20:18];
   assign dst     = instr[17:12];
   assign src1    = instr[11:6];
   assign src2    = instr[5:0];
   assign issue_c = (state == EXEC) && (pc < len_q);
   assign iss_vld = issue_c && (op[1:0] != 2'b00);
   assign opa     = rf_rd(src1);
   assign opb     = op[2] ? {{(DW-6){1'b0}}, src2} : rf_rd(src2);

   always_comb begin
      sum  = {1'b0, opa} + {1'b0, opb};
      diff = {1'b0, opa} - {1'b0, opb};
      prod = (2*DW)'(opa) * (2*DW)'(opb);
`ifdef TPFU_SAT_EN
      add_r = sum[DW]  ? '1 : sum[DW-1:0];
      sub_r = diff[DW] ? '0 : diff[DW-1:0];
      mul_r = (|prod[2*DW-1:DW]) ? '1 : prod[DW-1:0];
`else
      add_r = sum[DW-1:0];
      sub_r = diff[DW-1:0];
      mul_r = prod[DW-1:0];
`endif
      case (op[1:0])
         2'b01:   alu_r = add_r;
         2'b10:   alu_r = sub_r;
         2'b11:   alu_r = mul_r;
         default: alu_r = '0;
      endcase
   end

   logic unused_bits;
   assign unused_bits = ^{instr[23:21], sum[DW], diff[DW], prod[2*DW-1:DW]};

   // Control FSM
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         count     <= '0;
         pc        <= '0;
         len_q     <= '0;
         din_ready <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (din_valid) begin
                  count <= 7'd1;
                  state <= LOAD;
               end
            end
            LOAD: begin
               if (din_valid) count <= count + 7'd1;
               if (!din_valid || (count == 7'(RF_DEPTH - 1))) begin
                  state     <= EXEC;
                  din_ready <= 1'b0;
                  busy      <= 1'b1;
                  pc        <= '0;
                  len_q     <= prog_len;
               end
            end
            EXEC: begin
               if (issue_c) pc <= pc + (PM_AW+1)'(1);
               if ((len_q == '0) || (pc == len_q - (PM_AW+1)'(1))) state <= DRAIN;
            end
            DRAIN: begin
               // Only the output stage may still hold a result: finish the cycle after it retires
               if ((p_vld & ~LAST_MASK) == '0) begin
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  din_ready <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (prog_we && ((state == IDLE) || (state == LOAD)))
         pmem[prog_addr] <= prog_data;
   end

   // Writeback is assigned last so it wins over a same-address load
   always_ff @(posedge clk) begin
      if (ld_en) rf[ld_addr[RF_AW-1:0]] <= din;
      if (wb_en) rf[wb_dst[RF_AW-1:0]]  <= wb_data;
   end

   // Data/dst only advance with a valid so the output stage holds its last result
   always_ff @(posedge clk) begin
      if (rst) begin
         p_vld[0]  <= 1'b0;
         p_data[0] <= '0;
         p_dst[0]  <= '0;
      end else begin
         p_vld[0] <= iss_vld;
         if (iss_vld) begin
            p_data[0] <= alu_r;
            p_dst[0]  <= dst;
         end
      end
   end

   for (genvar k = 1; k < ALU_LAT; k++) begin : g_stage
      always_ff @(posedge clk) begin
         if (rst) begin
            p_vld[k]  <= 1'b0;
            p_data[k] <= '0;
            p_dst[k]  <= '0;
         end else begin
            p_vld[k] <= p_vld[k-1];
            if (p_vld[k-1]) begin
               p_data[k] <= p_data[k-1];
               p_dst[k]  <= p_dst[k-1];
            end
         end
      end
   end

   assign dout       = p_data[ALU_LAT-1];
   assign dout_valid = p_vld[ALU_LAT-1];

endmodule
